// File: rtl/sat_sum_window.sv
// Window accumulator for saturated sums: adds up to WINDOW beats (or fewer on in_last),
// saturates the total at all-ones, and emits one result per window through a stallable output register.
module sat_sum_window #(
  parameter int WIDTH  = 32,
  parameter int WINDOW = 8,
  localparam int CNT_W = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);

  typedef enum logic [1:0] {EMPTY, ACCUM, STALL} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_acc_q, sat_acc_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_sat_q, out_sat_d;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   acc_next;
  logic               sat_next;
  logic [CNT_W-1:0]   cnt_inc;
  logic               out_free;
  logic               accept;
  logic               close;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_acc_d   = sat_acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_sat_d   = out_sat_q;

    in_ready = !clear && (state_q != STALL);
    out_free = !out_valid_q || out_ready;
    accept   = in_valid && in_ready;

    sum     = {1'b0, acc_q} + {1'b0, in_data};
    cnt_inc = cnt_q + CNT_W'(1);
    if (sum[WIDTH] || sat_acc_q) begin
      acc_next = '1;
      sat_next = 1'b1;
    end else begin
      acc_next = sum[WIDTH-1:0];
      sat_next = sat_acc_q;
    end
    close = (cnt_inc == CNT_W'(WINDOW)) || in_last;

    // A consumed result drops here; a load below in the same cycle overrides it.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (state_q == STALL) begin
      if (clear) begin
        acc_d     = '0;
        cnt_d     = '0;
        sat_acc_d = 1'b0;
        state_d   = EMPTY;
      end else if (out_free) begin
        out_valid_d = 1'b1;
        out_data_d  = acc_q;
        out_count_d = cnt_q;
        out_sat_d   = sat_acc_q;
        acc_d       = '0;
        cnt_d       = '0;
        sat_acc_d   = 1'b0;
        state_d     = EMPTY;
      end
    end else if (clear) begin
      acc_d     = '0;
      cnt_d     = '0;
      sat_acc_d = 1'b0;
      state_d   = EMPTY;
    end else if (accept) begin
      if (close && out_free) begin
        out_valid_d = 1'b1;
        out_data_d  = acc_next;
        out_count_d = cnt_inc;
        out_sat_d   = sat_next;
        acc_d       = '0;
        cnt_d       = '0;
        sat_acc_d   = 1'b0;
        state_d     = EMPTY;
      end else begin
        // Closed window with a busy output parks in acc/cnt until the register frees up.
        acc_d     = acc_next;
        cnt_d     = cnt_inc;
        sat_acc_d = sat_next;
        state_d   = close ? STALL : ACCUM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_acc_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_acc_q   <= sat_acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_sat   = out_sat_q;

endmodule

// File: doc/sat_sum_window.md
Name: sat_sum_window

Overview:
- Downstream consumer of the registered saturating 32-bit adder stage.
- Accumulates successive saturated sums over a window of WINDOW beats, or fewer if closed early by in_last.
- Saturates the window total at all-ones and emits one result per window with a count and a sticky saturation flag.
- Valid/ready on both sides; a single output register plus a stall state gives full backpressure without data loss.

Parameters:
- WIDTH, 32, data width of input samples and of the window total.
- WINDOW, 8, beats per window (>=1).
- CNT_W, $clog2(WINDOW+1), width of the beat counter and of out_count (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-low.
- clear  in  1  synchronous abort of the window in progress.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  WIDTH  saturated sum from the upstream adder.
- in_last  in  1  closes the window on this beat regardless of count.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  saturated window total.
- out_count  out  CNT_W  number of beats in the window (1..WINDOW).
- out_sat  out  1  window total saturated.

Behaviour:
- Internal state: acc[WIDTH], cnt[CNT_W], sat_acc, FSM {EMPTY, ACCUM, STALL}; output register {out_valid, out_data, out_count, out_sat}.
- Reset (rst=0, async): state=EMPTY, acc=0, cnt=0, sat_acc=0, out_valid=0, out_data=0, out_count=0, out_sat=0.
- in_ready is combinational: in_ready = !clear && (state != STALL). It reads 1 after reset.
- Accepted beat:
  - Compute sum = {1'b0,acc} + {1'b0,in_data} at WIDTH+1 bits.
  - If sum[WIDTH] or sat_acc: acc_next = all-ones, sat_next = 1.
  - Otherwise acc_next = sum[WIDTH-1:0], sat_next = sat_acc.
  - Once set, saturation is sticky until the window closes.
- Close condition: an accepted beat with cnt+1 == WINDOW, or in_last=1.
- out_free = !out_valid || out_ready.
- EMPTY/ACCUM, accepted beat without close: acc <= acc_next, cnt <= cnt+1, sat_acc <= sat_next, state <= ACCUM.
- EMPTY/ACCUM, close with out_free:
  - Load out_data <= acc_next, out_count <= cnt+1, out_sat <= sat_next, out_valid <= 1.
  - Clear acc/cnt/sat_acc; state <= EMPTY.
  - Latency: out_valid is high the cycle after the closing beat.
- EMPTY/ACCUM, close with !out_free: acc <= acc_next, cnt <= cnt+1, sat_acc <= sat_next, state <= STALL.
- STALL:
  - in_ready = 0.
  - When out_free: load the output register from acc/cnt/sat_acc, clear them, state <= EMPTY. in_ready returns to 1 on the next cycle.
- Output handshake:
  - out_valid && out_ready with no load in the same cycle: out_valid <= 0.
  - Consume and load in the same cycle: out_valid stays 1 with the new data. No bubble.
  - Output register fields are stable while out_valid && !out_ready.
- clear=1 (sync), in EMPTY/ACCUM:
  - acc, cnt, sat_acc <= 0; state <= EMPTY.
  - in_ready is forced 0, so no beat is accepted that cycle.
  - The output register is unaffected.
- clear=1 in STALL: the pending closed window is discarded; state <= EMPTY. The output register is unaffected.
- WINDOW=1: every accepted beat closes; out_count is always 1.
- in_last on the first beat gives out_count=1.
- in_last together with cnt+1 == WINDOW is a single close; no double emission.
- rst asserted mid-window or mid-stall: all state drops immediately; no partial result is ever emitted.

Test Plan:
- Reset: rst low then high -> out_valid=0, out_data=0, out_count=0, in_ready=1.
- WINDOW=4, out_ready=1, beats 1,2,3,4 on consecutive cycles -> one cycle after beat 4: out_valid=1, out_data=10, out_count=4, out_sat=0; out_valid=0 the following cycle.
- Saturation, beats 0xFFFFFFF0, 0x20, 0, 0 -> out_data=0xFFFFFFFF, out_sat=1, out_count=4. The trailing zeros do not clear saturation.
- Backpressure, out_ready=0, eight beats of 1:
  - Window 1 loads the output (out_data=4).
  - Window 2 closes -> STALL, in_ready=0.
  - Raise out_ready for one cycle -> first result consumed, second (out_data=4, out_count=4) is valid the next cycle, in_ready=1.
- Early close, beats 5 then 7 with in_last on the second -> out_data=12, out_count=2. The next window starts from 0: beats 1,1,1,1 -> out_data=4.
- clear after two beats of 9, then beats 1,1,1,1 -> in_ready=0 during clear, result out_data=4, out_count=4.
- Reset mid-window: rst low mid-window -> out_valid drops immediately; no result is emitted for the aborted window.
